stage_enable_sequencer: RTL
===========================

// Module: stage_enable_sequencer
// PURPOSE
//  Parametrised successor to the 4-stage enable FSM of the floating-point datapath.
//  Maps an op code to an MSB-first thermometer enable mask over N_STAGES stages and ramps `en` toward it one stage per step.
//  Requests come from op changes (modo=0, auto) or from a synchronised, debounced button press (modo=1, step).
//  Emits a one-cycle `cambio` pulse when the mask settles. Sits between the board inputs and the FP stage enables.
// PARAMETERS
//  N_STAGES      4          number of stage enables (>=2)
//  OP_W          $clog2(N_STAGES+1)  op code width
//  STEP_CYC      1          clock cycles per one-bit ramp step (>=1)
//  SYNC_STAGES   2          button synchroniser flops (>=2)
//  DEBOUNCE_CYC  1_000_000  cycles the button must be stable before it is accepted (>=1)
// PORTS
//  clk     in   1         system clock, all logic on rising edge
//  rst     in   1         synchronous, active-high reset
//  boton   in   1         asynchronous push-button, raw
//  modo    in   1         0 = auto (op change triggers), 1 = step (button press triggers)
//  op      in   OP_W      requested configuration code
//  en      out  N_STAGES  stage enable mask, MSB-first thermometer
//  cambio  out  1         one-cycle pulse: en reached the target
//  busy    out  1         high while ramping
//  err     out  1         one-cycle pulse: illegal op request dropped
// BEHAVIOUR
//  Reset values (rst high at any edge, mid-ramp included):
//   - en=0, cambio=0, busy=0, err=0, state=IDLE.
//   - op_q=N_STAGES; debouncer stable=0, counter=0.
//  Target T(op):
//   - op<N_STAGES -> T=op+1 ones from MSB (N=4: 0->1000, 3->1111).
//   - op==N_STAGES -> T=0 (all off).
//   - op>N_STAGES -> illegal.
//  Request:
//   - modo=0: req when op!=op_q, sampled each edge; op_q<=op every edge regardless of modo.
//   - modo=1: req = rising edge of debounced button; op changes alone do nothing.
//  Debounce:
//   - boton passes SYNC_STAGES flops, giving sync.
//   - sync==stable -> counter cleared; else counter++.
//   - counter==DEBOUNCE_CYC-1 -> stable<=sync, counter cleared.
//   - Press pulse when stable goes 0->1; release generates nothing.
//  Illegal req: en and state unchanged; err=1 for the cycle after the request edge.
//  FSM IDLE/RAMP/DONE:
//   - IDLE, legal req: latch tgt; tgt==en -> DONE, else RAMP; step counter cleared.
//   - RAMP: every STEP_CYC-th cycle, en moves one bit toward tgt.
//     - Up: set the highest clear bit. Down: clear the lowest set bit.
//     - On the edge where en becomes tgt -> DONE.
//   - RAMP, legal req (retarget): tgt replaced; ramp continues from current en; step counter not cleared; new tgt==en -> DONE.
//   - DONE: cambio=1 for exactly this cycle; next edge -> IDLE.
//   - DONE, req on the same edge: req handled as if in IDLE (no lost request).
//  Outputs and timing:
//   - busy = (state==RAMP).
//   - All outputs registered.
//   - Latency, auto mode: op change -> first en change = STEP_CYC+1 edges; settle to cambio = |T-en|*STEP_CYC+1 edges.
//  modo toggling mid-ramp: ramp completes; only the trigger source changes.
//  Simultaneous illegal req and an in-progress ramp: ramp unaffected; err pulses.
// STRUCTURE
//  Shared package flot_pkg:
//   - state encoding localparams ST_IDLE/ST_RAMP/ST_DONE;
//   - function therm(n, N_STAGES) returning the MSB-first mask.
//  Sub-module boton_debounce (SYNC_STAGES, DEBOUNCE_CYC): boton -> press pulse.
//  Top: op_q compare, target decode, step counter, FSM, output registers.
// TESTING (N_STAGES=4, STEP_CYC=1, SYNC_STAGES=2, DEBOUNCE_CYC=4 unless stated)
//  - Reset 3 cycles, modo=0, op=4 -> en=0000, no cambio, no err.
//  - modo=0, op 4->2 at edge k:
//    - en=1000/1100/1110 after k+2/k+3/k+4;
//    - cambio=1 only in the cycle after k+4; busy high k+1..k+4.
//  - From 1110 set op=0 -> en 1100 then 1000, one cambio.
//  - Repeat with STEP_CYC=3: each en step 3 cycles apart.
//  - Retarget: ramp toward 1111 and change op to 0 when en=1100 -> en 1000, cambio once, no pulse for the abandoned target.
//  - modo=1, op=3:
//    - 2-cycle glitch on boton -> no change;
//    - boton held 10 cycles -> en ramps to 1111 after sync+debounce;
//    - release -> nothing.
//  - Illegal op=7 (OP_W=3) in modo=0 -> err one cycle, en and state unchanged.
//  - rst mid-ramp -> next cycle en=0000, busy=0, cambio=0.

Source files
------------

// File: rtl/flot_pkg.sv
// Package shared by the stage enable sequencer and its testbench.
//  - state_t     : sequencer FSM states (ST_IDLE, ST_RAMP, ST_DONE)
//  - MAX_STAGES  : widest mask that therm() can build
//  - therm()     : MSB-first thermometer mask with n ones across n_stages bits
package flot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned MAX_STAGES = 32;

  // Sets the n most significant bits of the low n_stages bits.
  // n larger than n_stages saturates to all ones.
  function automatic logic [MAX_STAGES-1:0] therm(input int unsigned n,
                                                  input int unsigned n_stages);
    logic [MAX_STAGES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_STAGES; i++) begin
      m[i] = (i < n_stages) && ((i + n) >= n_stages);
    end
    return m;
  endfunction

endpackage

// File: rtl/stage_enable_sequencer_if.sv
// Board-side bundle of the stage enable sequencer.
//  boton  : raw push-button (asynchronous)
//  modo   : 0 = auto (op change triggers), 1 = step (button press triggers)
//  op     : requested configuration code
//  en     : stage enable mask, MSB-first thermometer
//  cambio : one-cycle pulse when en reaches the target
//  busy   : high while ramping
//  err    : one-cycle pulse when an illegal op request is dropped
// master drives the requests, slave (the sequencer) drives the status.
interface stage_enable_sequencer_if #(
  parameter int N_STAGES = 4,
  parameter int OP_W     = $clog2(N_STAGES + 1)
);
  logic                boton;
  logic                modo;
  logic [OP_W-1:0]     op;
  logic [N_STAGES-1:0] en;
  logic                cambio;
  logic                busy;
  logic                err;

  modport master (output boton, modo, op, input en, cambio, busy, err);
  modport slave  (input boton, modo, op, output en, cambio, busy, err);
endinterface

// File: rtl/boton_debounce.sv
// Push-button synchroniser and debouncer.
//  clk     : system clock
//  rst     : synchronous active-high reset
//  boton_i : raw asynchronous button
//  press_o : one-cycle pulse when the debounced level goes 0 -> 1
// The synchronised level must differ from the accepted level for
// DEBOUNCE_CYC consecutive cycles before it is accepted. Releases are
// accepted the same way but produce no pulse.
module boton_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic boton_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   sync_s;

  assign sync_s  = sync_q[SYNC_STAGES-1];
  assign press_o = press_q;

  // Next-state: shift the synchroniser and run the stability counter.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], boton_i};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync_s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_s;
      cnt_d    = '0;
      press_d  = sync_s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

endmodule

// File: rtl/stage_enable_sequencer.sv
// Stage enable sequencer for the floating-point datapath.
//  clk : system clock, rising edge
//  rst : synchronous active-high reset
//  bus : stage_enable_sequencer_if.slave (boton/modo/op in, en/cambio/busy/err out)
// An op code selects an MSB-first thermometer target; en ramps toward it one
// bit every STEP_CYC cycles. Requests come from op changes (modo=0) or from a
// debounced button press (modo=1). All outputs come straight from flops.
module stage_enable_sequencer #(
  parameter int N_STAGES     = 4,
  parameter int OP_W         = $clog2(N_STAGES + 1),
  parameter int STEP_CYC     = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input logic                    clk,
  input logic                    rst,
  stage_enable_sequencer_if.slave bus
);
  import flot_pkg::*;

  localparam int SC_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STEP_CYC - 1);
  localparam logic [OP_W-1:0] OP_OFF  = OP_W'(N_STAGES);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [N_STAGES-1:0] en_q, en_d;
  logic [N_STAGES-1:0] tgt_q, tgt_d;
  logic [SC_W-1:0]     step_q, step_d;
  logic                cambio_q, cambio_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                press_s;
  logic                req_s;
  logic                legal_s;
  logic                acc_s;
  logic [N_STAGES-1:0] tgt_req_s;
  logic [N_STAGES-1:0] tgt_eff_s;
  logic [N_STAGES-1:0] en_step_s;

  boton_debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .boton_i (bus.boton),
    .press_o (press_s)
  );

  assign bus.en     = en_q;
  assign bus.cambio = cambio_q;
  assign bus.busy   = busy_q;
  assign bus.err    = err_q;

  // Request decode, target decode and one-step move of the mask.
  always_comb begin
    op_d      = bus.op;
    req_s     = bus.modo ? press_s : (bus.op != op_q);
    legal_s   = (bus.op <= OP_OFF);
    acc_s     = req_s & legal_s;
    if (bus.op < OP_OFF) begin
      tgt_req_s = N_STAGES'(therm(32'(bus.op) + 32'd1, N_STAGES));
    end else begin
      tgt_req_s = '0;
    end
    // A retarget takes effect on the edge it arrives.
    tgt_eff_s = acc_s ? tgt_req_s : tgt_q;
    // en is always a thermometer: more ones reads as a larger number, so a
    // magnitude compare gives the direction. Up shifts a one in at the MSB
    // (sets the highest clear bit); down clears the lowest set bit.
    if (tgt_eff_s > en_q) begin
      en_step_s = {1'b1, en_q[N_STAGES-1:1]};
    end else begin
      en_step_s = en_q & (en_q - N_STAGES'(1));
    end
  end

  // FSM next state and next register values for all outputs.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    case (state_q)
      // DONE behaves like IDLE so a request on the settle edge is not lost.
      ST_IDLE, ST_DONE: begin
        if (acc_s) begin
          tgt_d  = tgt_req_s;
          step_d = '0;
          if (tgt_req_s == en_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RAMP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RAMP: begin
        tgt_d = tgt_eff_s;
        if (tgt_eff_s == en_q) begin
          state_d = ST_DONE;
        end else if (step_q == SC_LAST) begin
          step_d = '0;
          en_d   = en_step_s;
          if (en_step_s == tgt_eff_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RAMP;
          end
        end else begin
          step_d  = step_q + SC_W'(1);
          state_d = ST_RAMP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cambio_d = (state_d == ST_DONE);
    busy_d   = (state_d == ST_RAMP);
    err_d    = req_s & ~legal_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_OFF;
      en_q     <= '0;
      tgt_q    <= '0;
      step_q   <= '0;
      cambio_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      en_q     <= en_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      cambio_q <= cambio_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

endmodule
